// File: rtl/mul_div_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// mul_div_sequencer_pkg
// Shared definitions for the multiply/divide sequencer: bus widths, the
// mode and ALU opcode encodings, and the sequencer state encoding.
// ---------------------------------------------------------------------------
package mul_div_sequencer_pkg;

   localparam int ADDR_W = 9;    // ROM address width
   localparam int DATA_W = 8;    // ROM data / operand width
   localparam int RES_W  = 16;   // result, remainder and ALU width

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

   localparam logic ALU_ADD = 1'b0;
   localparam logic ALU_SUB = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH_A,
      LOAD_A,
      LOAD_B,
      CHECK,
      RUN,
      DONE
   } stateT;

endpackage

// File: rtl/mul_div_sequencer_if.sv
// ---------------------------------------------------------------------------
// mul_div_sequencer_if
// Bundles every non-clock/reset signal of the sequencer.
//   start/mode/base_addr : request, sampled when the sequencer is IDLE/DONE
//   rom_addr/rom_data    : synchronous ROM, data valid one cycle after address
//   alu_a/alu_b/alu_op   : operands and opcode to the external ALU
//   alu_y                : combinational ALU result
//   result/remainder     : product or quotient, and division remainder
//   busy/done/div_zero   : status; done is a one-cycle pulse
// Modports: master = requester/ROM/ALU side, slave = sequencer.
// ---------------------------------------------------------------------------
interface mul_div_sequencer_if;
   import mul_div_sequencer_pkg::*;

   logic              start;
   logic              mode;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [RES_W-1:0]  alu_a;
   logic [RES_W-1:0]  alu_b;
   logic              alu_op;
   logic [RES_W-1:0]  alu_y;
   logic [RES_W-1:0]  result;
   logic [RES_W-1:0]  remainder;
   logic              busy;
   logic              done;
   logic              div_zero;

   modport master (
      output start, mode, base_addr, rom_data, alu_y,
      input  rom_addr, alu_a, alu_b, alu_op, result, remainder,
             busy, done, div_zero
   );

   modport slave (
      input  start, mode, base_addr, rom_data, alu_y,
      output rom_addr, alu_a, alu_b, alu_op, result, remainder,
             busy, done, div_zero
   );

endinterface

// File: rtl/mul_div_sequencer.sv
// ---------------------------------------------------------------------------
// mul_div_sequencer
// Fetches two 8-bit operands from an external synchronous ROM and computes
// A*B by repeated addition or A/B (quotient and remainder) by repeated
// subtraction, using an external combinational ALU.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : mul_div_sequencer_if.slave (request, ROM, ALU and status)
// ---------------------------------------------------------------------------
module mul_div_sequencer
   import mul_div_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   mul_div_sequencer_if.slave bus
);

   stateT             stateQ;
   stateT             stateD;
   logic              modeQ;
   logic [ADDR_W-1:0] romAddrQ;
   logic [DATA_W-1:0] regA;
   logic [DATA_W-1:0] regB;
   logic [DATA_W-1:0] cnt;
   logic [RES_W-1:0]  acc;
   logic [RES_W-1:0]  rem;
   logic [RES_W-1:0]  quot;
   logic [RES_W-1:0]  resultQ;
   logic [RES_W-1:0]  remainderQ;
   logic              divZeroQ;

   logic [RES_W-1:0]  aExt;
   logic [RES_W-1:0]  bExt;
   logic              startOk;
   logic              skipRun;
   logic              runLast;

   assign aExt    = {{(RES_W-DATA_W){1'b0}}, regA};
   assign bExt    = {{(RES_W-DATA_W){1'b0}}, regB};
   assign startOk = bus.start && ((stateQ == IDLE) || (stateQ == DONE));

   // Zero iterations: B==0 in either mode, or a quotient of zero.
   assign skipRun = (regB == '0) || ((modeQ == MODE_DIV) && (regA < regB));

   // Multiply stops on the last count; divide stops once the new partial
   // remainder has dropped below the divisor.
   assign runLast = (modeQ == MODE_MUL) ? (cnt == DATA_W'(1)) : (bus.alu_y < bExt);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values; reset is asynchronous and clears all state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stateQ <= IDLE;
      end else begin
         stateQ <= stateD;
      end
   end

   // NOTE: next state is defaulted before the case so no path infers a latch.
   always_comb begin
      stateD = stateQ;
      case (stateQ)
         IDLE,
         DONE:    stateD = startOk ? FETCH_A : IDLE;
         FETCH_A: stateD = LOAD_A;
         LOAD_A:  stateD = LOAD_B;
         LOAD_B:  stateD = CHECK;
         CHECK:   stateD = skipRun ? DONE : RUN;
         RUN:     stateD = runLast ? DONE : RUN;
         default: stateD = IDLE;
      endcase
   end

   // Datapath registers, updated according to the current state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         modeQ      <= MODE_MUL;
         romAddrQ   <= '0;
         regA       <= '0;
         regB       <= '0;
         cnt        <= '0;
         acc        <= '0;
         rem        <= '0;
         quot       <= '0;
         resultQ    <= '0;
         remainderQ <= '0;
         divZeroQ   <= 1'b0;
      end else begin
         case (stateQ)
            IDLE,
            DONE: begin
               if (startOk) begin
                  modeQ    <= bus.mode;
                  romAddrQ <= bus.base_addr;
                  divZeroQ <= 1'b0;
               end
            end
            FETCH_A: romAddrQ <= romAddrQ + ADDR_W'(1);   // wraps mod 512
            LOAD_A:  regA     <= bus.rom_data;
            LOAD_B:  regB     <= bus.rom_data;
            CHECK: begin
               if (modeQ == MODE_MUL) begin
                  acc <= '0;
                  cnt <= regB;
                  if (regB == '0) begin
                     resultQ    <= '0;
                     remainderQ <= '0;
                  end
               end else if (regB == '0) begin
                  divZeroQ   <= 1'b1;
                  resultQ    <= '1;
                  remainderQ <= aExt;
               end else if (regA < regB) begin
                  resultQ    <= '0;
                  remainderQ <= aExt;
               end else begin
                  rem  <= aExt;
                  quot <= '0;
               end
            end
            RUN: begin
               if (modeQ == MODE_MUL) begin
                  acc <= bus.alu_y;
                  cnt <= cnt - DATA_W'(1);
                  if (runLast) begin
                     resultQ    <= bus.alu_y;
                     remainderQ <= '0;
                  end
               end else begin
                  rem  <= bus.alu_y;
                  quot <= quot + RES_W'(1);
                  if (runLast) begin
                     resultQ    <= quot + RES_W'(1);
                     remainderQ <= bus.alu_y;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ALU operands follow the latched mode in every state so they are always
   // driven from registers; they only matter in RUN.
   always_comb begin
      bus.alu_a  = acc;
      bus.alu_b  = aExt;
      bus.alu_op = ALU_ADD;
      if (modeQ == MODE_DIV) begin
         bus.alu_a  = rem;
         bus.alu_b  = bExt;
         bus.alu_op = ALU_SUB;
      end
   end

   assign bus.rom_addr  = romAddrQ;
   assign bus.result    = resultQ;
   assign bus.remainder = remainderQ;
   assign bus.div_zero  = divZeroQ;
   assign bus.busy      = (stateQ != IDLE) && (stateQ != DONE);
   assign bus.done      = (stateQ == DONE);

endmodule

// File: doc/mul_div_sequencer.md
MUL_DIV_SEQUENCER -- requirements
Module: mul_div_sequencer

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge system clock; reset_n in 1, asynchronous active-low reset (one clock, no other reset).
REQ-002 SHALL have start in 1: request, sampled on clk when state is IDLE or DONE.
REQ-003 SHALL have mode in 1: 0 = multiply, 1 = divide; sampled with start.
REQ-004 SHALL have base_addr in 9: operand A at base_addr, B at base_addr+1 (wraps mod 512); sampled with start.
REQ-005 SHALL have rom_addr out 9 and rom_data in 8: synchronous ROM, data valid the cycle after address is presented.
REQ-006 SHALL have alu_a out 16, alu_b out 16, alu_op out 1 (0 add, 1 sub), alu_y in 16 (combinational ALU result).
REQ-007 SHALL have result out 16 (product/quotient), remainder out 16, busy out 1, done out 1, div_zero out 1.

Function
REQ-008 SHALL implement states IDLE, FETCH_A, LOAD_A, LOAD_B, CHECK, RUN, DONE.
REQ-009 start=1 at edge k in IDLE/DONE SHALL latch mode/base_addr and enter FETCH_A; start elsewhere SHALL be ignored.
REQ-010 FETCH_A: rom_addr=base; LOAD_A: rom_addr=base+1, A<=rom_data at exit edge; LOAD_B: B<=rom_data at exit edge; other states rom_addr holds last value.
REQ-011 CHECK (mul): acc<=0, cnt<=B; B==0 -> DONE else RUN.
REQ-012 CHECK (div): B==0 -> div_zero<=1, result<=16'hFFFF, remainder<={8'h00,A}, DONE; A<B -> result<=0, remainder<=A, DONE; else rem<=A, q<=0, RUN.
REQ-013 RUN (mul): alu_a=acc, alu_b={8'h00,A}, alu_op=0; each edge acc<=alu_y, cnt<=cnt-1; cnt==1 -> DONE.
REQ-014 RUN (div): alu_a=rem, alu_b={8'h00,B}, alu_op=1; each edge rem<=alu_y, q<=q+1; alu_y<B -> DONE.
REQ-015 result SHALL equal acc (mul) or q (div); remainder SHALL equal rem (div), 0 for mul; outputs 16-bit, no overflow possible (max 65025).
REQ-016 Iteration count N = B (mul), floor(A/B) (div), 0 for B==0 or A<B; done SHALL be high exactly in the cycle after edge k+4+N.
REQ-017 done SHALL be a one-cycle pulse in DONE; DONE -> IDLE unless start accepted (back-to-back -> FETCH_A).
REQ-018 busy SHALL be 1 in FETCH_A..RUN, 0 in IDLE and DONE.
REQ-019 result/remainder/div_zero SHALL hold after DONE until next accepted start; div_zero cleared at FETCH_A entry.
REQ-020 alu_a/alu_b/alu_op outside RUN SHALL be driven from current registers (don't-care to ALU, never X).

Reset
REQ-021 reset_n=0 SHALL immediately force IDLE and clear rom_addr, A, B, acc, cnt, rem, q, result, remainder, busy, done, div_zero to 0.
REQ-022 Reset mid-operation SHALL abort with no done pulse; first start after release SHALL behave as from power-up.

Structure
REQ-023 Shared package SHALL hold state encoding, MODE_MUL/MODE_DIV, ALU_ADD/ALU_SUB, ADDR_W=9, DATA_W=8, RES_W=16.
REQ-024 Block SHALL be flat (no sub-module); ROM and ALU stay external.

Verification
REQ-025 mul, ROM[0x010]=7, ROM[0x011]=9 -> result=0x003F, remainder=0, done in cycle after edge k+13.
REQ-026 mul 255x255 -> result=0xFE01, busy for 259 cycles; mul B=0 -> result=0, done after edge k+4.
REQ-027 div 100/7 -> result=14, remainder=2, div_zero=0, done after edge k+18; div 3/8 -> result=0, remainder=3, done after edge k+4.
REQ-028 div 5/0 -> div_zero=1, result=0xFFFF, remainder=5, done after edge k+4.
REQ-029 base_addr=0x1FF -> B read from 0x000.
REQ-030 start pulsed mid-RUN ignored; reset_n low mid-RUN -> all outputs 0 immediately, no done; start in DONE cycle -> back-to-back run correct.
